uart_rx_pro: RTL and testbench

UART_RX_PRO -- requirements
Module: uart_rx_pro

---
 rtl/uart_rx_pro.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_pro.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pro.sv
// UART receiver: 2-flop synchroniser, 3-sample majority vote per bit, optional parity,
// 1-2 stop bits, and a show-ahead receive FIFO with overrun detection.
module uart_rx_pro #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        po_data,
    output logic                        po_valid,
    input  logic                        po_ready,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF         = BAUD_CNT_MAX / 2;
    localparam int BAUD_W       = $clog2(BAUD_CNT_MAX);
    localparam int AW           = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
    } state_e;

    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_ok_q, par_ok_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];

    logic fall, at_s0, at_s1, at_s2, at_wrap, maj;
    logic last_data, last_stop, stop_ok, push_req, push, pop, full;

    assign fall      = rx_prev_q & ~rx_s2_q;
    assign at_s0     = baud_cnt_q == BAUD_W'(HALF - 1);
    assign at_s1     = baud_cnt_q == BAUD_W'(HALF);
    assign at_s2     = baud_cnt_q == BAUD_W'(HALF + 1);
    assign at_wrap   = baud_cnt_q == BAUD_W'(BAUD_CNT_MAX - 1);
    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
    assign last_data = bit_idx_q == 3'(DATA_BITS - 1);
    assign last_stop = bit_idx_q == 3'(STOP_BITS - 1);
    assign stop_ok   = ~stop_bad_q & maj;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (fall) state_d = ST_START;
            ST_START:     if (at_s2 && maj) state_d = ST_IDLE;
                          else if (at_wrap) state_d = ST_DATA;
            ST_DATA:      if (at_wrap && last_data) state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (at_wrap) state_d = ST_STOP;
            ST_STOP:      if (at_s2 && last_stop) state_d = stop_ok ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (rx_s2_q) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Frame verdict is taken at the majority point of the last stop bit.
    always_comb begin
        push_req     = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        if (state_q == ST_STOP && at_s2 && last_stop) begin
            if (!stop_ok)       frame_err_d  = 1'b1;
            else if (!par_ok_q) parity_err_d = 1'b1;
            else                push_req     = 1'b1;
        end
    end

    always_comb begin
        baud_cnt_d = at_wrap ? '0 : baud_cnt_q + 1'b1;
        if (state_q inside {ST_IDLE, ST_WAIT_HIGH} || state_d inside {ST_IDLE, ST_WAIT_HIGH})
            baud_cnt_d = '0;
        samp_d     = samp_q;
        if (at_s0) samp_d[0] = rx_s2_q;
        if (at_s1) samp_d[1] = rx_s2_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        stop_bad_d = stop_bad_q;
        case (state_q)
            ST_IDLE:   bit_idx_d = '0;
            ST_START: begin
                par_ok_d   = 1'b1;
                stop_bad_d = 1'b0;
            end
            ST_DATA: begin
                if (at_s2)   shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                if (at_wrap) bit_idx_d = last_data ? 3'd0 : bit_idx_q + 3'd1;
            end
            ST_PARITY: if (at_s2) par_ok_d = ((^shift_q) ^ maj) == (PARITY == 1);
            ST_STOP: begin
                if (at_s2 && !maj) stop_bad_d = 1'b1;
                if (at_wrap)       bit_idx_d  = bit_idx_q + 3'd1;
            end
            default: ;
        endcase
    end

    assign full     = cnt_q == (AW + 1)'(FIFO_DEPTH);
    assign po_valid = cnt_q != '0;
    assign pop      = po_valid & po_ready;
    assign push     = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overrun_d = push_req & full & ~pop;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt_q   <= '0;
            samp_q       <= 2'b11;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b1;
            stop_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            baud_cnt_q   <= baud_cnt_d;
            samp_q       <= samp_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            stop_bad_q   <= stop_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // NOTE: FIFO storage carries no reset; po_data is forced to 0 whenever the FIFO is empty.
    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= shift_q;
    end

    assign po_data    = po_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign fifo_cnt   = cnt_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_pro.sv
// Bench for uart_rx_pro: an 8N1 instance (a) and a 7-bit even-parity, 2-stop instance (b),
// driven with directed and random frames and scored against a frame-level outcome model.
module tb_uart_rx_pro;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BPS      = 100_000;
    localparam int BIT_CYC  = CLK_FREQ / BPS;

    typedef enum int {GOOD, PAR_BAD, FRAME_BAD} outcome_e;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
    logic [2:0] cnt_a, cnt_b;

    always #5 sys_clk = ~sys_clk;

    uart_rx_pro #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_a), .po_data(data_a),
        .po_valid(valid_a), .po_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a),
        .overrun(ov_a), .fifo_cnt(cnt_a));

    uart_rx_pro #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_b), .po_data(data_b),
        .po_valid(valid_b), .po_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b),
        .overrun(ov_b), .fifo_cnt(cnt_b));

    int vectors = 0, miscompares = 0;

    // Monitor: only ever appends/accumulates; the stimulus side keeps its own read marks.
    logic [7:0] got_a[$], got_b[$];
    int n_fe_a = 0, n_pe_a = 0, n_ov_a = 0, n_vc_a = 0;
    int n_fe_b = 0, n_pe_b = 0, n_ov_b = 0;
    int rd_a = 0, rd_b = 0, b_fe_a = 0, b_pe_a = 0, b_ov_a = 0, b_vc_a = 0;
    int b_fe_b = 0, b_pe_b = 0, b_ov_b = 0;

    always @(negedge sys_clk) begin
        if (valid_a && rdy_a) got_a.push_back(data_a);
        if (valid_b && rdy_b) got_b.push_back({1'b0, data_b});
        n_fe_a += int'(fe_a);
        n_pe_a += int'(pe_a);
        n_ov_a += int'(ov_a);
        n_vc_a += int'(valid_a);
        n_fe_b += int'(fe_b);
        n_pe_b += int'(pe_b);
        n_ov_b += int'(ov_b);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        rd_a = got_a.size();  rd_b = got_b.size();
        b_fe_a = n_fe_a; b_pe_a = n_pe_a; b_ov_a = n_ov_a; b_vc_a = n_vc_a;
        b_fe_b = n_fe_b; b_pe_b = n_pe_b; b_ov_b = n_ov_b;
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic drive_bit(input bit sel, input logic v, input bit spike);
        set_rx(sel, v);
        repeat (BIT_CYC / 2) @(posedge sys_clk);
        if (spike) set_rx(sel, ~v);
        @(posedge sys_clk);
        set_rx(sel, v);
        repeat (BIT_CYC / 2 - 1) @(posedge sys_clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input int nd, input bit has_par,
                              input logic pbit, input int nstop, input logic [1:0] stops,
                              input int spike_bit, input int tail_low);
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nd; i++) drive_bit(sel, d[i], i == spike_bit);
        if (has_par) drive_bit(sel, pbit, 1'b0);
        for (int i = 0; i < nstop; i++) drive_bit(sel, stops[i], 1'b0);
        if (tail_low > 0) begin
            set_rx(sel, 1'b0);
            repeat (tail_low) @(posedge sys_clk);
        end
        set_rx(sel, 1'b1);
        repeat (BIT_CYC / 2) @(posedge sys_clk);
    endtask

    // Frame-level reference: stop bits decide first, then parity, otherwise the word is delivered.
    function automatic outcome_e predict(input logic [7:0] d, input int nd, input int pmode,
                                         input logic pbit, input int nstop, input logic [1:0] stops);
        int ones;
        for (int i = 0; i < nstop; i++) if (stops[i] == 1'b0) return FRAME_BAD;
        if (pmode == 0) return GOOD;
        ones = int'(pbit);
        for (int i = 0; i < nd; i++) ones += int'(d[i]);
        if (pmode == 1) return (ones % 2 == 1) ? GOOD : PAR_BAD;
        return (ones % 2 == 0) ? GOOD : PAR_BAD;
    endfunction

    task automatic score(input bit sel, input string tag, input logic [7:0] d, input outcome_e exp);
        int pushes, fe, pe, ov;
        logic [7:0] head;
        @(negedge sys_clk);
        if (sel) begin
            pushes = got_b.size() - rd_b;
            head   = (pushes > 0) ? got_b[rd_b] : 8'h00;
            fe = n_fe_b - b_fe_b; pe = n_pe_b - b_pe_b; ov = n_ov_b - b_ov_b;
        end else begin
            pushes = got_a.size() - rd_a;
            head   = (pushes > 0) ? got_a[rd_a] : 8'h00;
            fe = n_fe_a - b_fe_a; pe = n_pe_a - b_pe_a; ov = n_ov_a - b_ov_a;
        end
        check({tag, " pushes"}, pushes, (exp == GOOD) ? 1 : 0);
        if (exp == GOOD) check({tag, " data"}, head, d);
        check({tag, " frame_err"}, fe, (exp == FRAME_BAD) ? 1 : 0);
        check({tag, " parity_err"}, pe, (exp == PAR_BAD) ? 1 : 0);
        check({tag, " overrun"}, ov, 0);
        mark();
    endtask

    initial begin
        logic [7:0] d;
        logic       pbit;
        logic [1:0] stops;
        outcome_e   exp;

        // Reset values
        repeat (3) @(negedge sys_clk);
        check("rst po_valid", valid_a, 1'b0);
        check("rst po_data", data_a, 8'h00);
        check("rst fifo_cnt", cnt_a, 3'd0);
        check("rst flags", {fe_a, pe_a, ov_a}, 3'b000);
        check("rst b fifo_cnt", {valid_b, cnt_b}, 4'h0);
        sys_rst_n = 1'b1;
        repeat (2 * BIT_CYC) @(posedge sys_clk);
        mark();

        // 8N1 0xA5, single po_valid cycle
        send_frame(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1, 2'b11, -1, 0);
        check("a5 valid cycles", n_vc_a - b_vc_a, 1);
        score(1'b0, "a5", 8'hA5, GOOD);

        // 2-cycle glitch on an idle line is a false start
        rx_a = 1'b0;
        repeat (2) @(posedge sys_clk);
        rx_a = 1'b1;
        repeat (2 * BIT_CYC) @(posedge sys_clk);
        @(negedge sys_clk);
        check("glitch fifo_cnt", cnt_a, 3'd0);
        check("glitch flags", (n_fe_a - b_fe_a) + (n_pe_a - b_pe_a) + (got_a.size() - rd_a), 0);
        mark();

        // One-cycle mid-bit spikes are outvoted
        send_frame(1'b0, 8'h00, 8, 1'b0, 1'b0, 1, 2'b11, 3, 0);
        score(1'b0, "spike 00", 8'h00, GOOD);
        send_frame(1'b0, 8'hFF, 8, 1'b0, 1'b0, 1, 2'b11, 6, 0);
        score(1'b0, "spike ff", 8'hFF, GOOD);

        // Random 8N1 frames, occasional bad stop bit
        for (int k = 0; k < 12; k++) begin
            d     = 8'($urandom);
            stops = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
            exp   = predict(d, 8, 0, 1'b0, 1, stops);
            send_frame(1'b0, d, 8, 1'b0, 1'b0, 1, stops, -1, 0);
            score(1'b0, $sformatf("rand8n1[%0d]", k), d, exp);
        end

        // 7E2: 0x41 with wrong then right parity bit
        send_frame(1'b1, 8'h41, 7, 1'b1, 1'b1, 2, 2'b11, -1, 0);
        score(1'b1, "7e 41 bad par", 8'h41, PAR_BAD);
        check("7e bad par fifo_cnt", cnt_b, 3'd0);
        send_frame(1'b1, 8'h41, 7, 1'b1, 1'b0, 2, 2'b11, -1, 0);
        score(1'b1, "7e 41 good", 8'h41, GOOD);

        // Random 7E2 frames: mostly correct parity, some corrupted stop bits
        for (int k = 0; k < 12; k++) begin
            d     = 8'($urandom_range(0, 127));
            pbit  = ^d;
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            exp   = predict(d, 7, 2, pbit, 2, stops);
            send_frame(1'b1, d, 7, 1'b1, pbit, 2, stops, -1, 0);
            score(1'b1, $sformatf("rand7e2[%0d]", k), d, exp);
        end

        // Bad stop bit followed by a held-low line: exactly one frame_err
        send_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0, 1, 2'b10, -1, 3 * BIT_CYC);
        score(1'b0, "break 3c", 8'h3C, FRAME_BAD);
        send_frame(1'b0, 8'h11, 8, 1'b0, 1'b0, 1, 2'b11, -1, 0);
        score(1'b0, "after break 11", 8'h11, GOOD);

        // Overrun: five frames into a four-deep FIFO with the consumer stalled
        rdy_a = 1'b0;
        for (int v = 1; v <= 5; v++) send_frame(1'b0, 8'(v), 8, 1'b0, 1'b0, 1, 2'b11, -1, 0);
        @(negedge sys_clk);
        check("ovr fifo_cnt", cnt_a, 3'd4);
        check("ovr pulses", n_ov_a - b_ov_a, 1);
        check("ovr head stable", data_a, 8'h01);
        rdy_a = 1'b1;
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        check("ovr drained", got_a.size() - rd_a, 4);
        for (int i = 0; i < 4; i++)
            if (got_a.size() > rd_a + i) check($sformatf("ovr order[%0d]", i), got_a[rd_a + i], 8'(i + 1));
        check("ovr valid low", valid_a, 1'b0);
        mark();

        // Reset mid-frame with two buffered words
        rdy_a = 1'b0;
        send_frame(1'b0, 8'h21, 8, 1'b0, 1'b0, 1, 2'b11, -1, 0);
        send_frame(1'b0, 8'h42, 8, 1'b0, 1'b0, 1, 2'b11, -1, 0);
        @(negedge sys_clk);
        check("pre-rst fifo_cnt", cnt_a, 3'd2);
        d = 8'h5A;
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i], 1'b0);
        rx_a = d[4];
        repeat (BIT_CYC / 2) @(posedge sys_clk);
        sys_rst_n = 1'b0;
        rx_a      = 1'b1;
        #1;
        check("midrst outputs", {valid_a, data_a, cnt_a, fe_a, pe_a, ov_a}, 15'h0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2 * BIT_CYC) @(posedge sys_clk);
        @(negedge sys_clk);
        check("post-rst idle cnt", cnt_a, 3'd0);
        mark();
        send_frame(1'b0, 8'h7E, 8, 1'b0, 1'b0, 1, 2'b11, -1, 0);
        @(negedge sys_clk);
        check("post-rst fifo_cnt", cnt_a, 3'd1);
        check("post-rst po_data", data_a, 8'h7E);
        rdy_a = 1'b1;
        repeat (4) @(posedge sys_clk);
        score(1'b0, "post-rst 7e", 8'h7E, GOOD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
